// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with stall, flush, forwarding select and bubble counter
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic [9:0]        funct_i,
  input  logic [6:0]        ctrl_i,
  input  logic              exmem_regwrite_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic              memwb_regwrite_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  output logic [DATA_W-1:0] rs1_data_o,
  output logic [DATA_W-1:0] rs2_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [REG_AW-1:0] rs1_addr_o,
  output logic [REG_AW-1:0] rs2_addr_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic [9:0]        funct_o,
  output logic [6:0]        ctrl_o,
  output logic              valid_o,
  output logic [1:0]        forward_a_o,
  output logic [1:0]        forward_b_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  logic [DATA_W-1:0] r_rs1_data;
  logic [DATA_W-1:0] r_rs2_data;
  logic [DATA_W-1:0] r_imm;
  logic [REG_AW-1:0] r_rs1_addr;
  logic [REG_AW-1:0] r_rs2_addr;
  logic [REG_AW-1:0] r_rd_addr;
  logic [9:0]        r_funct;
  logic [6:0]        r_ctrl;
  logic              r_valid;
  logic [CNT_W-1:0]  r_bubble_cnt;
  logic [1:0]        w_fwd_a;
  logic [1:0]        w_fwd_b;

  // 10 = EX/MEM result, 01 = MEM/WB data, 00 = register-file value; x0 never forwards
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic              ex_we,
    input logic [REG_AW-1:0] ex_rd,
    input logic              wb_we,
    input logic [REG_AW-1:0] wb_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (ex_we && (ex_rd != '0) && (ex_rd == rs)) begin
      sel = 2'b10;
    end else if (wb_we && (wb_rd != '0) && (wb_rd == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // Pipeline payload: flush beats stall, stall holds, otherwise capture
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd_addr  <= '0;
      r_funct    <= '0;
      r_ctrl     <= '0;
      r_valid    <= 1'b0;
    end else if (flush_i) begin
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd_addr  <= '0;
      r_funct    <= '0;
      r_ctrl     <= '0;
      r_valid    <= 1'b0;
    end else if (!stall_i) begin
      r_rs1_data <= rs1_data_i;
      r_rs2_data <= rs2_data_i;
      r_imm      <= imm_i;
      r_rs1_addr <= rs1_addr_i;
      r_rs2_addr <= rs2_addr_i;
      r_rd_addr  <= rd_addr_i;
      r_funct    <= funct_i;
      r_ctrl     <= ctrl_i;
      r_valid    <= 1'b1;
    end
  end

  // Saturating count of flush cycles; stall has no effect on it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bubble_cnt <= '0;
    end else if (flush_i && (r_bubble_cnt != {CNT_W{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  // Forwarding selects from registered sources against live downstream destinations
  always_comb begin
    w_fwd_a = fwd_sel(r_rs1_addr, exmem_regwrite_i, exmem_rd_i, memwb_regwrite_i, memwb_rd_i);
    w_fwd_b = fwd_sel(r_rs2_addr, exmem_regwrite_i, exmem_rd_i, memwb_regwrite_i, memwb_rd_i);
  end

  assign rs1_data_o   = r_rs1_data;
  assign rs2_data_o   = r_rs2_data;
  assign imm_o        = r_imm;
  assign rs1_addr_o   = r_rs1_addr;
  assign rs2_addr_o   = r_rs2_addr;
  assign rd_addr_o    = r_rd_addr;
  assign funct_o      = r_funct;
  assign ctrl_o       = r_ctrl;
  assign valid_o      = r_valid;
  assign forward_a_o  = w_fwd_a;
  assign forward_b_o  = w_fwd_b;
  assign bubble_cnt_o = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb/tb_id_ex_stage_reg.sv - scoreboard bench for id_ex_stage_reg
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [4:0]  rda;
    logic [9:0]  funct;
    logic [6:0]  ctrl;
    logic        valid;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } obs_t;

  logic clk = 1'b0;
  logic rst, stall, flush;
  logic [31:0] rs1d, rs2d, imm;
  logic [4:0]  rs1a, rs2a, rda;
  logic [9:0]  funct;
  logic [6:0]  ctrl;
  logic        exrw, wbrw;
  logic [4:0]  exrd, wbrd;

  logic [31:0] o_rs1d, o_rs2d, o_imm;
  logic [4:0]  o_rs1a, o_rs2a, o_rda;
  logic [9:0]  o_funct;
  logic [6:0]  o_ctrl;
  logic        o_valid;
  logic [1:0]  o_fa, o_fb;
  logic [15:0] o_cnt;

  logic [31:0] s_rs1d, s_rs2d, s_imm;
  logic [4:0]  s_rs1a, s_rs2a, s_rda;
  logic [9:0]  s_funct;
  logic [6:0]  s_ctrl;
  logic        s_valid;
  logic [1:0]  s_fa, s_fb;
  logic [3:0]  s_cnt;

  obs_t  exp;
  obs_t  exp_q[$];
  string name_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  event  chk_ev;

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .rs1_data_i(rs1d), .rs2_data_i(rs2d), .imm_i(imm),
    .rs1_addr_i(rs1a), .rs2_addr_i(rs2a), .rd_addr_i(rda),
    .funct_i(funct), .ctrl_i(ctrl),
    .exmem_regwrite_i(exrw), .exmem_rd_i(exrd),
    .memwb_regwrite_i(wbrw), .memwb_rd_i(wbrd),
    .rs1_data_o(o_rs1d), .rs2_data_o(o_rs2d), .imm_o(o_imm),
    .rs1_addr_o(o_rs1a), .rs2_addr_o(o_rs2a), .rd_addr_o(o_rda),
    .funct_o(o_funct), .ctrl_o(o_ctrl), .valid_o(o_valid),
    .forward_a_o(o_fa), .forward_b_o(o_fb), .bubble_cnt_o(o_cnt)
  );

  id_ex_stage_reg #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .rs1_data_i(rs1d), .rs2_data_i(rs2d), .imm_i(imm),
    .rs1_addr_i(rs1a), .rs2_addr_i(rs2a), .rd_addr_i(rda),
    .funct_i(funct), .ctrl_i(ctrl),
    .exmem_regwrite_i(exrw), .exmem_rd_i(exrd),
    .memwb_regwrite_i(wbrw), .memwb_rd_i(wbrd),
    .rs1_data_o(s_rs1d), .rs2_data_o(s_rs2d), .imm_o(s_imm),
    .rs1_addr_o(s_rs1a), .rs2_addr_o(s_rs2a), .rd_addr_o(s_rda),
    .funct_o(s_funct), .ctrl_o(s_ctrl), .valid_o(s_valid),
    .forward_a_o(s_fa), .forward_b_o(s_fb), .bubble_cnt_o(s_cnt)
  );

  function automatic obs_t snap();
    obs_t o;
    o.rs1d = o_rs1d; o.rs2d = o_rs2d; o.imm = o_imm;
    o.rs1a = o_rs1a; o.rs2a = o_rs2a; o.rda = o_rda;
    o.funct = o_funct; o.ctrl = o_ctrl; o.valid = o_valid;
    o.fa = o_fa; o.fb = o_fb; o.cnt = o_cnt; o.cnt4 = s_cnt;
    return o;
  endfunction

  // Monitor: drains expectations on every falling edge, or at once for async checks
  initial begin
    forever begin
      @(negedge clk or chk_ev);
      while (exp_q.size() > 0) begin
        obs_t  e;
        obs_t  a;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        a = snap();
        n_vec++;
        if (a !== e) begin
          n_err++;
          $display("FAIL %s: got %h expected %h", n, a, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic push(input string n);
    exp_q.push_back(exp);
    name_q.push_back(n);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a();
    rs1d = 32'h1234_5678; rs2d = 32'hCAFE_BABE; imm = 32'hFFFF_FFF0;
    rs1a = 5'd5; rs2a = 5'd0; rda = 5'd7; funct = 10'h205; ctrl = 7'b1000101;
  endtask

  task automatic expect_a();
    exp.rs1d = 32'h1234_5678; exp.rs2d = 32'hCAFE_BABE; exp.imm = 32'hFFFF_FFF0;
    exp.rs1a = 5'd5; exp.rs2a = 5'd0; exp.rda = 5'd7; exp.funct = 10'h205;
    exp.ctrl = 7'b1000101; exp.valid = 1'b1;
  endtask

  task automatic expect_bubble();
    exp.rs1d = '0; exp.rs2d = '0; exp.imm = '0; exp.rs1a = '0; exp.rs2a = '0;
    exp.rda = '0; exp.funct = '0; exp.ctrl = '0; exp.valid = 1'b0;
    exp.fa = 2'b00; exp.fb = 2'b00;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    rs1d = '0; rs2d = '0; imm = '0; rs1a = '0; rs2a = '0; rda = '0;
    funct = '0; ctrl = '0; exrw = 1'b0; exrd = '0; wbrw = 1'b0; wbrd = '0;
    exp = '0;
    #3;
    push("reset_init");
    -> chk_ev;

    step();
    rst = 1'b0;

    // Plain capture, no forwarding sources active
    step();
    drive_a();
    edge_wait();
    expect_a(); exp.fa = 2'b00; exp.fb = 2'b00;
    push("capture");

    // Stall with changing inputs: everything frozen
    for (int i = 0; i < 3; i++) begin
      step();
      stall = 1'b1;
      rs1d = 32'hDEAD_0000 + i; rs2d = 32'hBEEF_0000 + i; imm = 32'h0000_0100 + i;
      rs1a = 5'(10 + i); rs2a = 5'(20 + i); rda = 5'(i + 1);
      funct = 10'(i + 3); ctrl = 7'(7'h10 + i);
      edge_wait();
      push($sformatf("stall%0d", i));
    end

    // Flush together with stall: flush wins
    step();
    flush = 1'b1; stall = 1'b1;
    edge_wait();
    expect_bubble(); exp.cnt = 16'd1; exp.cnt4 = 4'd1;
    push("flush_and_stall");

    step();
    flush = 1'b0; stall = 1'b0;
    drive_a();
    edge_wait();
    expect_a();
    push("recapture");

    // Forwarding priority on operand A (rs1=5), rs2=0 stays 00
    step();
    stall = 1'b1;
    exrw = 1'b1; exrd = 5'd5; wbrw = 1'b1; wbrd = 5'd5;
    exp.fa = 2'b10; exp.fb = 2'b00;
    push("fwd_a_exmem");

    step();
    exrw = 1'b0;
    exp.fa = 2'b01;
    push("fwd_a_memwb");

    step();
    wbrw = 1'b0;
    exp.fa = 2'b00;
    push("fwd_a_none");

    // x0 guard: writers target x0 and rs2=0
    step();
    exrw = 1'b1; exrd = 5'd0; wbrw = 1'b1; wbrd = 5'd0;
    exp.fa = 2'b00; exp.fb = 2'b00;
    push("fwd_x0_guard");

    // Second instruction: rs1=3, rs2=9
    step();
    stall = 1'b0;
    rs1d = 32'h0BAD_F00D; rs2d = 32'h0000_0042; imm = 32'h0000_07FF;
    rs1a = 5'd3; rs2a = 5'd9; rda = 5'd31; funct = 10'h3FF; ctrl = 7'b0011010;
    exrw = 1'b1; exrd = 5'd9; wbrw = 1'b1; wbrd = 5'd3;
    edge_wait();
    exp.rs1d = 32'h0BAD_F00D; exp.rs2d = 32'h0000_0042; exp.imm = 32'h0000_07FF;
    exp.rs1a = 5'd3; exp.rs2a = 5'd9; exp.rda = 5'd31; exp.funct = 10'h3FF;
    exp.ctrl = 7'b0011010; exp.valid = 1'b1; exp.fa = 2'b01; exp.fb = 2'b10;
    push("capture_b_fwd");

    step();
    stall = 1'b1;
    exrd = 5'd3; wbrd = 5'd9;
    exp.fa = 2'b10; exp.fb = 2'b01;
    push("fwd_swap");

    step();
    exrd = 5'd9; wbrd = 5'd9;
    exp.fa = 2'b00; exp.fb = 2'b10;
    push("fwd_b_priority");

    // Flush alone: bubble forwards nothing
    step();
    stall = 1'b0; flush = 1'b1;
    edge_wait();
    expect_bubble(); exp.cnt = 16'd2; exp.cnt4 = 4'd2;
    push("flush_only");

    // Async reset asserted mid-stall
    step();
    flush = 1'b0;
    drive_a();
    edge_wait();
    expect_a(); exp.fa = 2'b00; exp.fb = 2'b00;
    push("capture_pre_reset");
    step();
    stall = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    exp = '0;
    push("async_reset_mid_stall");
    -> chk_ev;

    // First edge after release captures normally
    step();
    rst = 1'b0; stall = 1'b0;
    exrw = 1'b0; wbrw = 1'b0;
    drive_a();
    edge_wait();
    expect_a(); exp.fa = 2'b00; exp.fb = 2'b00;
    push("capture_after_reset");

    // 20 back-to-back flushes: 4-bit counter saturates
    step();
    flush = 1'b1;
    expect_bubble();
    for (int i = 0; i < 20; i++) begin
      edge_wait();
      if (i == 13) begin
        exp.cnt = 16'd14; exp.cnt4 = 4'hE;
        push("sat_14");
      end else if (i == 14) begin
        exp.cnt = 16'd15; exp.cnt4 = 4'hF;
        push("sat_15");
      end else if (i == 19) begin
        exp.cnt = 16'd20; exp.cnt4 = 4'hF;
        push("sat_20");
      end
    end

    step();
    flush = 1'b0;
    step();
    step();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register for the 5-stage RISC-V core.
- Latches decoded operands, register addresses and control bits at the ID→EX boundary. Supports hold (stall) and bubble insertion (flush).
- Generates the 2-bit operand-select codes consumed by the EX-stage forwarding muxes, comparing its registered rs1/rs2 against the EX/MEM and MEM/WB destinations.
- Keeps a saturating bubble counter for performance observation.

Parameters:
- DATA_W, 32, width of operand and immediate fields
- REG_AW, 5, register-address width
- CNT_W, 16, bubble counter width

Ports:
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  asynchronous, active-high reset
- stall_i  input  1  hold all registered fields this cycle
- flush_i  input  1  load a bubble this cycle
- rs1_data_i  input  DATA_W  RS1 value from the register file
- rs2_data_i  input  DATA_W  RS2 value from the register file
- imm_i  input  DATA_W  sign-extended immediate
- rs1_addr_i  input  REG_AW  RS1 index
- rs2_addr_i  input  REG_AW  RS2 index
- rd_addr_i  input  REG_AW  destination index
- funct_i  input  10  {funct7, funct3}
- ctrl_i  input  7  {RegWrite, MemtoReg, MemRead, MemWrite, ALUOp[1:0], ALUSrc}
- exmem_regwrite_i  input  1  EX/MEM RegWrite
- exmem_rd_i  input  REG_AW  EX/MEM destination
- memwb_regwrite_i  input  1  MEM/WB RegWrite
- memwb_rd_i  input  REG_AW  MEM/WB destination
- rs1_data_o, rs2_data_o, imm_o  output  DATA_W  registered operands
- rs1_addr_o, rs2_addr_o, rd_addr_o  output  REG_AW  registered indices
- funct_o  output  10  registered funct
- ctrl_o  output  7  registered control
- valid_o  output  1  EX-stage slot holds a real instruction
- forward_a_o  output  2  select for the ALU operand A mux
- forward_b_o  output  2  select for the ALU operand B (pre-ALUSrc) mux
- bubble_cnt_o  output  CNT_W  number of flush cycles since reset

Behaviour:
- Reset: the asynchronous assertion of rst_i forces every registered output to 0, including valid_o and bubble_cnt_o. forward_a_o and forward_b_o are therefore 00.
- Each rising edge follows this priority:
  - rst_i high: stay in reset.
  - else flush_i high: load a bubble. All data, address, funct and ctrl fields go to 0, valid_o=0, and bubble_cnt_o increments.
  - else stall_i high: hold all fields; valid_o holds.
  - else: capture all *_i fields and set valid_o=1.
- Simultaneous flush_i and stall_i: flush wins.
- Latency: exactly 1 cycle from ID inputs to registered outputs.
- bubble_cnt_o saturates at all-ones and never wraps. It is not affected by stall.
- Forwarding is combinational from the registered rs1/rs2_addr_o and the live EX/MEM and MEM/WB inputs.
- forward_a_o is encoded as follows (forward_b_o is identical, using rs2_addr_o):
  - 10 (take EX/MEM ALU result): exmem_regwrite_i=1, exmem_rd_i≠0 and exmem_rd_i==rs1_addr_o.
  - else 01 (take MEM/WB write-back data): memwb_regwrite_i=1, memwb_rd_i≠0 and memwb_rd_i==rs1_addr_o.
  - else 00 (use the registered register-file value).
- Encoding contract with the EX mux: 00 selects the ID/EX value, 01 selects the MEM/WB data, 10 selects the EX/MEM data. 11 is never produced.
- x0 is never forwarded, even when RegWrite=1 with rd=0.
- A bubble has rs1/rs2=0, so its forward codes are always 00.
- Reset asserted mid-stall or mid-flush clears state immediately, without waiting for a clock edge. The first edge after deassertion follows the normal priority.

Test Plan:
- Reset: assert rst_i between clock edges → all outputs 0 without waiting for an edge; bubble_cnt_o=0.
- Capture: rs1_data_i=0x1234_5678, rd_addr_i=7, ctrl_i=7'b1000101, then one edge → outputs match; valid_o=1.
- Stall and flush:
  - stall_i=1 for 3 cycles with changing inputs → outputs frozen.
  - Then flush_i=1 with stall_i=1 → ctrl_o=0, valid_o=0, bubble_cnt_o=1.
- Forwarding priority: rs1_addr_o=5, exmem (RegWrite=1, rd=5), memwb (RegWrite=1, rd=5) → forward_a_o=10. Drop exmem_regwrite_i → 01. Drop memwb_regwrite_i → 00.
- x0 guard: rs2_addr_o=0, exmem_rd_i=0 with RegWrite=1 → forward_b_o=00.
- Saturation: CNT_W=4 build, 20 consecutive flushes → bubble_cnt_o holds 4'hF.
